// File: rtl/uart_edge_pulse_gen.sv
// uart_edge_pulse_gen
//   Multi-channel synchronising edge-to-pulse generator. Each channel has
//   these stages:
//     - a synchroniser chain;
//     - an optional debounce filter;
//     - an edge detector with a per-channel mode (off/rise/fall/both);
//     - a retriggerable pulse stretcher;
//     - a sticky event flag.
//   Events are suppressed during a short warm-up after reset release, so
//   stale levels are not reported as edges.
//
//   Optional feature macro: UART_PULSE_GEN_DEBOUNCE_EN
//     When defined, a channel's filtered level follows the synchronised level
//     only after the two have differed for DEB_CYCLES consecutive clocks.
//     When undefined, the filtered level is the synchronised level.
//
// Ports:
//   i_pulse_gen_clk        clock
//   i_pulse_gen_rst        asynchronous active-high reset
//   i_pulse_gen_lvl_sig    [NUM_CH]   asynchronous level inputs
//   i_pulse_gen_mode       [2*NUM_CH] channel k mode at [2k+1:2k]:
//                                     00 off, 01 rise, 10 fall, 11 both
//   i_pulse_gen_flag_clr   [NUM_CH]   sticky flag clear
//   o_pulse_gen_pulse_sig  [NUM_CH]   stretched event pulses
//   o_pulse_gen_flag       [NUM_CH]   sticky event flags
//   o_pulse_gen_any        OR of all pulse outputs
module uart_edge_pulse_gen #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned PULSE_LEN   = 1,
   parameter int unsigned DEB_CYCLES  = 4
) (
   input  logic                  i_pulse_gen_clk,
   input  logic                  i_pulse_gen_rst,
   input  logic [NUM_CH-1:0]     i_pulse_gen_lvl_sig,
   input  logic [2*NUM_CH-1:0]   i_pulse_gen_mode,
   input  logic [NUM_CH-1:0]     i_pulse_gen_flag_clr,
   output logic [NUM_CH-1:0]     o_pulse_gen_pulse_sig,
   output logic [NUM_CH-1:0]     o_pulse_gen_flag,
   output logic                  o_pulse_gen_any
);

   localparam int unsigned CW = $clog2(PULSE_LEN + 1);
`ifdef UART_PULSE_GEN_DEBOUNCE_EN
   localparam int unsigned WARM = SYNC_STAGES + 1 + DEB_CYCLES;
`else
   localparam int unsigned WARM = SYNC_STAGES + 1;
`endif
   localparam int unsigned WW = $clog2(WARM + 1);
   localparam logic [CW-1:0] LOAD = CW'(PULSE_LEN);

   logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q;
   logic [NUM_CH-1:0]                  synced;
   logic [NUM_CH-1:0]                  filt;
   logic [NUM_CH-1:0]                  prev;
   logic [NUM_CH-1:0]                  evt;
   logic [NUM_CH-1:0]                  flag;
   logic [CW-1:0]                      cnt [NUM_CH];
   logic [WW-1:0]                      warm_cnt;
   logic                               warm_done;

   // Synchroniser chains for all channels, packed side by side
   always_ff @(posedge i_pulse_gen_clk or posedge i_pulse_gen_rst) begin
      if (i_pulse_gen_rst) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= i_pulse_gen_lvl_sig;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

`ifdef UART_PULSE_GEN_DEBOUNCE_EN
   localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

   logic [DW-1:0] deb_cnt [NUM_CH];

   // The filtered level adopts the synced level on the DEB_CYCLES-th
   // consecutive clock of disagreement; any agreement restarts the window
   always_ff @(posedge i_pulse_gen_clk or posedge i_pulse_gen_rst) begin
      if (i_pulse_gen_rst) begin
         filt <= '0;
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            deb_cnt[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (synced[k] == filt[k]) begin
               deb_cnt[k] <= '0;
            end else if (deb_cnt[k] == DEB_LAST) begin
               filt[k]    <= synced[k];
               deb_cnt[k] <= '0;
            end else begin
               deb_cnt[k] <= deb_cnt[k] + 1'b1;
            end
         end
      end
   end
`else
   assign filt = synced;
`endif

   // The warm-up counter saturates at WARM, and warm_done is decoded from it.
   // The previous-level register keeps tracking during warm-up, so a level
   // that is held through reset release never looks like an edge.
   always_ff @(posedge i_pulse_gen_clk or posedge i_pulse_gen_rst) begin
      if (i_pulse_gen_rst) begin
         warm_cnt <= '0;
         prev     <= '0;
      end else begin
         prev <= filt;
         if (!warm_done) begin
            warm_cnt <= warm_cnt + 1'b1;
         end
      end
   end

   assign warm_done = (warm_cnt == WW'(WARM));

   always_comb begin
      evt = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         evt[k] = warm_done &
                  ((i_pulse_gen_mode[2*k]   &  filt[k] & ~prev[k]) |
                   (i_pulse_gen_mode[2*k+1] & ~filt[k] &  prev[k]));
      end
   end

   // An event always reloads the counter, so back-to-back events stretch
   // a single pulse instead of splitting it
   always_ff @(posedge i_pulse_gen_clk or posedge i_pulse_gen_rst) begin
      if (i_pulse_gen_rst) begin
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            cnt[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (evt[k]) begin
               cnt[k] <= LOAD;
            end else if (cnt[k] != '0) begin
               cnt[k] <= cnt[k] - 1'b1;
            end
         end
      end
   end

   // Set has priority over clear, so an event that coincides with a clear
   // is not lost
   always_ff @(posedge i_pulse_gen_clk or posedge i_pulse_gen_rst) begin
      if (i_pulse_gen_rst) begin
         flag <= '0;
      end else begin
         flag <= evt | (flag & ~i_pulse_gen_flag_clr);
      end
   end

   always_comb begin
      o_pulse_gen_pulse_sig = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         o_pulse_gen_pulse_sig[k] = (cnt[k] != '0);
      end
   end

   assign o_pulse_gen_flag = flag;
   assign o_pulse_gen_any  = |o_pulse_gen_pulse_sig;

endmodule

// File: tb/tb_uart_edge_pulse_gen.sv
// Testbench for uart_edge_pulse_gen in the default build: NUM_CH=4,
// SYNC_STAGES=2, and PULSE_LEN=3, so that stretching and retrigger are
// exercised. Expected outputs come from a history-based reference model.
// The model recomputes them each cycle as follows:
//   - the filtered level seen by the edge detector at edge E is the input
//     sampled at edge E-SYNC;
//   - an event fires at edge E when the mode enables that edge and the
//     warm-up has expired;
//   - the pulse is high while fewer than PULSE_LEN edges have passed since
//     the last event.
module tb_uart_edge_pulse_gen;

   localparam int NCH  = 4;
   localparam int SYNC = 2;
   localparam int PLEN = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NCH-1:0]   lvl = '0;
   logic [2*NCH-1:0] mode = '0;
   logic [NCH-1:0]   clr = '0;
   logic [NCH-1:0]   pulse;
   logic [NCH-1:0]   flag;
   logic             any;

   typedef struct packed {
      logic [NCH-1:0] pulse;
      logic [NCH-1:0] flag;
      logic           any;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;

   // reference model state
   logic [NCH-1:0] hist[$];
   int             edges = 0;
   int             last_ev [NCH];
   logic [NCH-1:0] mflag = '0;

   uart_edge_pulse_gen #(
      .NUM_CH      (NCH),
      .SYNC_STAGES (SYNC),
      .PULSE_LEN   (PLEN),
      .DEB_CYCLES  (4)
   ) dut (
      .i_pulse_gen_clk       (clk),
      .i_pulse_gen_rst       (rst),
      .i_pulse_gen_lvl_sig   (lvl),
      .i_pulse_gen_mode      (mode),
      .i_pulse_gen_flag_clr  (clr),
      .o_pulse_gen_pulse_sig (pulse),
      .o_pulse_gen_flag      (flag),
      .o_pulse_gen_any       (any)
   );

   always #5 clk = ~clk;

   function automatic logic [NCH-1:0] sample_at(int j);
      if (j >= 1 && j <= hist.size()) return hist[j-1];
      return '0;
   endfunction

   // Model: one expected record is pushed per clock edge
   always @(posedge clk) begin : model
      exp_t           x;
      logic [NCH-1:0] f;
      logic [NCH-1:0] p;
      logic           ev;
      x = '0;
      if (rst) begin
         hist.delete();
         edges = 0;
         for (int i = 0; i < NCH; i++) last_ev[i] = -1000;
         mflag = '0;
      end else begin
         edges++;
         hist.push_back(lvl);
         f = sample_at(edges - SYNC);
         p = sample_at(edges - SYNC - 1);
         for (int k = 0; k < NCH; k++) begin
            ev = (edges >= SYNC + 2) &&
                 ((mode[2*k]   &&  f[k] && !p[k]) ||
                  (mode[2*k+1] && !f[k] &&  p[k]));
            if (ev) begin
               last_ev[k] = edges;
               mflag[k]   = 1'b1;
            end else if (clr[k]) begin
               mflag[k] = 1'b0;
            end
            x.pulse[k] = (edges - last_ev[k]) < PLEN;
         end
         x.flag = mflag;
         x.any  = |x.pulse;
      end
      sbq.push_back(x);
   end

   // Monitor: pops one expected record per cycle, clear of the edge
   always @(posedge clk) begin : monitor
      exp_t e;
      #1;
      total++;
      if (sbq.size() == 0) begin
         bad++;
         $display("FAIL sb_empty t=%0t no expected entry", $time);
      end else begin
         e = sbq.pop_front();
         if (pulse !== e.pulse || flag !== e.flag || any !== e.any) begin
            bad++;
            $display("FAIL cycle t=%0t got pulse=%b flag=%b any=%b want pulse=%b flag=%b any=%b",
                     $time, pulse, flag, any, e.pulse, e.flag, e.any);
         end
      end
   end

   task automatic drive_random();
      @(negedge clk);
      for (int k = 0; k < NCH; k++) begin
         if ($urandom_range(0, 3) == 0) lvl[k] = ~lvl[k];
      end
      clr = NCH'($urandom) & NCH'($urandom);
      if ($urandom_range(0, 31) == 0) mode = (2*NCH)'($urandom);
   endtask

   task automatic async_reset_check();
      bit seen = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         drive_random();
         if (any === 1'b1) seen = 1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL mid_pulse_wait no pulse within 200 cycles");
      end
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (pulse !== '0 || flag !== '0 || any !== 1'b0) begin
         bad++;
         $display("FAIL async_reset got pulse=%b flag=%b any=%b want all 0",
                  pulse, flag, any);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      // Level held high through reset release must produce nothing
      rst  = 1'b1;
      lvl  = '1;
      mode = {NCH{2'b01}};
      clr  = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      mode = {NCH{2'b11}};
      repeat (3000) drive_random();

      async_reset_check();
      repeat (1000) drive_random();

      // Reset while inputs are high, then release with modes active
      async_reset_check();
      lvl = '1;
      repeat (10) @(negedge clk);
      repeat (500) drive_random();

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_edge_pulse_gen.md
Name: uart_edge_pulse_gen

Overview:
Multi-channel synchronising edge-to-pulse generator for the UART/config subsystem. It generalises the single-channel level-to-pulse block with:
- a synchroniser per channel
- a selectable edge mode per channel (rise/fall/both/off)
- programmable pulse stretching with retrigger
- sticky per-channel event flags
- post-reset warm-up suppression

It converts asynchronous level inputs (RX activity, config strobes, line-status levels) into clean single-clock-domain pulses.

Parameters:
- NUM_CH, 4, number of independent channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- PULSE_LEN, 1, output pulse width in clock cycles (1..255).
- DEB_CYCLES, 4, debounce stability window in cycles (>=1); used only with the optional feature.

Ports:
- i_pulse_gen_clk  in  1  clock.
- i_pulse_gen_rst  in  1  reset, asynchronous, active-high.
- i_pulse_gen_lvl_sig  in  NUM_CH  asynchronous level inputs, one per channel.
- i_pulse_gen_mode  in  2*NUM_CH  channel k mode at bits [2k+1:2k]: 00 off, 01 rising, 10 falling, 11 both.
- i_pulse_gen_flag_clr  in  NUM_CH  per-channel sticky-flag clear, sampled each clock.
- o_pulse_gen_pulse_sig  out  NUM_CH  stretched event pulses.
- o_pulse_gen_flag  out  NUM_CH  sticky event flags.
- o_pulse_gen_any  out  1  OR of all o_pulse_gen_pulse_sig bits (combinational).

Behaviour:
- Reset asserted: all flops (sync chains, previous-level regs, pulse counters, flags, warm-up counter) clear to 0 immediately, without a clock edge.
  - All outputs are 0 while reset is asserted.
- Per channel, signal flow:
  - s = last synchroniser stage.
  - f = filtered level (f = s without the optional feature).
  - p = f delayed one clock.
  - rise = f & ~p; fall = ~f & p.
  - event = (mode[0] & rise) | (mode[1] & fall), gated by warm_done.
- Warm-up:
  - Counter runs from reset release for SYNC_STAGES+1 cycles (plus DEB_CYCLES when debounce is compiled in); warm_done is then set and stays set.
  - Events are suppressed before warm_done; p still tracks f.
  - An input held high across reset release produces no pulse and no flag.
- Latency: an input change meeting setup before clock edge N loads the pulse counter at edge N+SYNC_STAGES. The output is high from that edge.
- Pulse counter, width ceil(log2(PULSE_LEN+1)):
  - Loads PULSE_LEN on event; otherwise decrements when non-zero.
  - pulse_sig = (cnt != 0), decoded from the register only, so it is glitch-free.
- Retrigger: an event while cnt != 0 reloads PULSE_LEN, so the pulse extends and is never split. Adjacent edges therefore merge into one long pulse.
- Mode 00:
  - No events are generated; any pulse already in progress drains normally.
  - Sync chain and p keep tracking, so enabling a mode later creates no spurious edge from stale history.
- Mode change takes effect on the next clock; a pulse in progress completes.
- Flag:
  - Set on event; cleared on flag_clr.
  - Event and clr in the same cycle: flag = 1 (set wins, no event lost).
  - flag_clr during warm-up is harmless.
- Channels are fully independent; simultaneous events on all channels are all captured.
- Counter saturation is not possible: load and decrement never wrap below 0.

Optional Feature:
UART_PULSE_GEN_DEBOUNCE_EN:
- Defined:
  - A per-channel debounce stage sits between s and f. f copies s only after s != f for DEB_CYCLES consecutive clocks.
  - The stability counter resets whenever s == f.
  - Reset value of f is 0.
  - Adds DEB_CYCLES to latency and to warm-up.
  - A glitch shorter than DEB_CYCLES produces no event.
- Undefined: f = s, DEB_CYCLES is ignored, and no debounce flops are instantiated.

Test Plan:
- Defaults; hold lvl=4'hF through reset; mode=01 on all channels; release reset and run 20 clocks -> pulse_sig=0, flag=0, any=0 throughout.
- PULSE_LEN=1; ch0 mode 01; lvl[0] 0->1 just before edge N -> pulse_sig[0]=1 for exactly one cycle after edge N+2, flag[0]=1; lvl[0] 1->0 -> no pulse.
- PULSE_LEN=3; ch1 mode 11; lvl[1] rises, then falls 2 clocks later -> one continuous 5-cycle pulse on ch1 (reload at the second event); any mirrors it.
- flag[2] already set; flag_clr[2]=1 in the same cycle a new ch2 event fires -> flag[2] stays 1; flag_clr[2] alone next cycle -> flag[2]=0.
- ch3 mode 00 while toggling lvl[3] -> no pulse, no flag. Then switch to mode 10 with lvl[3] steady low -> no pulse; next 1->0 transition -> pulse after SYNC_STAGES edges. Assert reset mid-pulse -> all outputs 0 with no clock edge.
- With UART_PULSE_GEN_DEBOUNCE_EN, DEB_CYCLES=4: a 3-cycle high glitch -> no event; a 5-cycle high level -> one pulse, 4 cycles later than in the non-debounced build.
